// File: rtl/beams_sort_idx_gen.sv
// Beam-selection index generator: accumulates per-beam energy over one
// 4x16-channel symbol, then ranks the 64 beams and emits the top 16.
module beams_sort_idx_gen #(
    parameter int IQ_WIDTH  = 16,
    parameter int ACC_WIDTH = 48
) (
    input  logic                               i_clk,
    input  logic                               i_reset,
    input  logic                               i_valid,
    input  logic                               i_sop,
    input  logic                               i_eop,
    input  logic [15:0][2*IQ_WIDTH-1:0]        i_data,
    output logic [15:0][7:0]                   o_sort_idx,
    output logic                               o_sort_sop,
    output logic                               o_busy,
    output logic                               o_overrun
);

    localparam int PW = 2*IQ_WIDTH+1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ACCUM = 2'd1;
    localparam logic [1:0] S_SORT  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]           r_state;
    logic [1:0]           r_blk;
    logic                 r_last;
    logic                 r_last2;
    logic                 r_pv;
    logic                 r_psop;
    logic [1:0]           r_pblk;
    logic [PW-1:0]        r_pow [16];
    logic [ACC_WIDTH-1:0] r_acc [64];
    logic [6:0]           r_cnt;
    logic [3:0]           r_pass;
    logic [63:0]          r_picked;
    logic                 r_have;
    logic [ACC_WIDTH-1:0] r_max;
    logic [5:0]           r_win;
    logic [5:0]           r_res [16];

    logic                 w_accept;
    logic [PW-1:0]        w_pow [16];
    logic [ACC_WIDTH:0]   w_sum [16];
    logic [ACC_WIDTH-1:0] w_cand;
    logic                 w_take;

    function automatic logic [PW-1:0] f_pow(input logic [2*IQ_WIDTH-1:0] d);
        logic signed [IQ_WIDTH-1:0]   vi;
        logic signed [IQ_WIDTH-1:0]   vq;
        logic signed [2*IQ_WIDTH-1:0] pi;
        logic signed [2*IQ_WIDTH-1:0] pq;
        vi = d[IQ_WIDTH-1:0];
        vq = d[2*IQ_WIDTH-1:IQ_WIDTH];
        pi = vi * vi;
        pq = vq * vq;
        return {1'b0, pi} + {1'b0, pq};
    endfunction

    // Beats are taken only while accumulating and not draining the last block
    assign w_accept = i_valid &
                      (((r_state == S_IDLE) & i_sop) |
                       ((r_state == S_ACCUM) & ~r_last & ~r_last2));

    always_comb begin
        for (int c = 0; c < 16; c++) begin
            w_pow[c] = f_pow(i_data[c]);
            w_sum[c] = {1'b0, r_acc[{r_pblk, 4'(c)}]}
                     + (ACC_WIDTH+1)'(r_pow[c]);
        end
    end

    assign w_cand = r_acc[r_cnt[5:0]];
    assign w_take = ~r_picked[r_cnt[5:0]] & (~r_have | (w_cand > r_max));

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_pv   <= 1'b0;
            r_psop <= 1'b0;
            r_pblk <= 2'd0;
            for (int c = 0; c < 16; c++) r_pow[c] <= '0;
        end else begin
            r_pv   <= w_accept;
            r_psop <= i_sop;
            r_pblk <= r_blk;
            for (int c = 0; c < 16; c++) r_pow[c] <= w_pow[c];
        end
    end

    // First beat of a block overwrites, so no clear pass is needed
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int b = 0; b < 64; b++) r_acc[b] <= '0;
        end else if (r_pv) begin
            for (int c = 0; c < 16; c++) begin
                if (r_psop)
                    r_acc[{r_pblk, 4'(c)}] <= ACC_WIDTH'(r_pow[c]);
                else if (w_sum[c][ACC_WIDTH])
                    r_acc[{r_pblk, 4'(c)}] <= '1;
                else
                    r_acc[{r_pblk, 4'(c)}] <= w_sum[c][ACC_WIDTH-1:0];
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state    <= S_IDLE;
            r_blk      <= 2'd0;
            r_last     <= 1'b0;
            r_last2    <= 1'b0;
            r_cnt      <= 7'd0;
            r_pass     <= 4'd0;
            r_picked   <= '0;
            r_have     <= 1'b0;
            r_max      <= '0;
            r_win      <= 6'd0;
            o_sort_sop <= 1'b0;
            o_busy     <= 1'b0;
            o_overrun  <= 1'b0;
            for (int i = 0; i < 16; i++) begin
                r_res[i]      <= 6'd0;
                o_sort_idx[i] <= 8'(i);
            end
        end else begin
            o_sort_sop <= 1'b0;
            o_overrun  <= i_valid &
                          ((r_state == S_SORT) | (r_state == S_DONE));
            r_last     <= 1'b0;
            r_last2    <= r_last;
            if (w_accept & i_eop) begin
                r_blk <= r_blk + 2'd1;
                if (r_blk == 2'd3) r_last <= 1'b1;
            end
            case (r_state)
                S_IDLE: begin
                    if (i_valid & i_sop) begin
                        r_state <= S_ACCUM;
                        o_busy  <= 1'b1;
                    end
                end
                S_ACCUM: begin
                    if (r_last2) begin
                        r_state  <= S_SORT;
                        r_cnt    <= 7'd0;
                        r_pass   <= 4'd0;
                        r_picked <= '0;
                        r_have   <= 1'b0;
                    end
                end
                S_SORT: begin
                    if (r_cnt == 7'd64) begin
                        r_res[r_pass]   <= r_win;
                        r_picked[r_win] <= 1'b1;
                        r_have          <= 1'b0;
                        r_cnt           <= 7'd0;
                        r_pass          <= r_pass + 4'd1;
                        if (r_pass == 4'd15) r_state <= S_DONE;
                    end else begin
                        if (w_take) begin
                            r_have <= 1'b1;
                            r_max  <= w_cand;
                            r_win  <= r_cnt[5:0];
                        end
                        r_cnt <= r_cnt + 7'd1;
                    end
                end
                default: begin
                    for (int i = 0; i < 16; i++)
                        o_sort_idx[i] <= {2'b00, r_res[i]};
                    o_sort_sop <= 1'b1;
                    o_busy     <= 1'b0;
                    r_state    <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_beams_sort_idx_gen.sv
// Randomized bench for beams_sort_idx_gen with a rank-based energy model.
module tb_beams_sort_idx_gen;

    localparam int     AW   = 34;
    localparam longint AMAX = (longint'(1) << AW) - 1;

    logic              clk = 1'b0;
    logic              rst;
    logic              valid;
    logic              sop;
    logic              eop;
    logic [15:0][31:0] data;
    logic [15:0][7:0]  sort_idx;
    logic              sort_sop;
    logic              busy;
    logic              overrun;

    always #5 clk = ~clk;

    beams_sort_idx_gen #(.IQ_WIDTH(16), .ACC_WIDTH(AW)) u_dut (
        .i_clk      (clk),
        .i_reset    (rst),
        .i_valid    (valid),
        .i_sop      (sop),
        .i_eop      (eop),
        .i_data     (data),
        .o_sort_idx (sort_idx),
        .o_sort_sop (sort_sop),
        .o_busy     (busy),
        .o_overrun  (overrun)
    );

    longint cyc = 0;
    int     nvec = 0;
    int     nerr = 0;
    int     sop_cnt = 0;
    int     ovr_cnt = 0;
    longint e [64];
    int     exp_idx [16];
    longint t_eop;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (sort_sop) sop_cnt++;
        if (overrun) ovr_cnt++;
    end

    task automatic check(input string tag, input longint got, input longint expv);
        nvec++;
        if (got !== expv) begin
            nerr++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, expv);
        end
    endtask

    task automatic idle_cycle();
        @(negedge clk);
        valid = 1'b0;
        sop   = 1'b0;
        eop   = 1'b0;
        data  = '0;
    endtask

    function automatic void chan_val(input int mode, input int beam,
                                     output int vi, output int vq);
        case (mode)
            0: begin vi = beam; vq = 0; end
            1: begin vi = 100; vq = 100; end
            2: begin vi = (beam == 40) ? 101 : 100; vq = 100; end
            3: begin
                vi = (beam == 5 || beam == 9) ? -32768 : 1;
                vq = (beam == 5 || beam == 9) ? -32768 : 0;
            end
            default: begin
                vi = int'($urandom_range(65535)) - 32768;
                vq = int'($urandom_range(65535)) - 32768;
            end
        endcase
    endfunction

    task automatic drive_beat(input int b, input int k, input int nb,
                              input int mode, input bit model);
        int vi, vq, beam;
        longint s;
        @(negedge clk);
        valid = 1'b1;
        sop   = (k == 0);
        eop   = (k == nb - 1);
        for (int c = 0; c < 16; c++) begin
            beam = 16*b + c;
            chan_val(mode, beam, vi, vq);
            data[c] = {vq[15:0], vi[15:0]};
            if (model) begin
                s = e[beam] + longint'(vi)*vi + longint'(vq)*vq;
                e[beam] = (s > AMAX) ? AMAX : s;
            end
        end
        if (model && b == 3 && k == nb - 1) t_eop = cyc;
    endtask

    task automatic send_symbol(input int mode);
        int nb, r;
        for (int j = 0; j < 64; j++) e[j] = 0;
        for (int b = 0; b < 4; b++) begin
            nb = (mode == 4) ? int'($urandom_range(6, 1)) : 8;
            for (int k = 0; k < nb; k++) begin
                if (mode == 4 && $urandom_range(3) == 0) idle_cycle();
                drive_beat(b, k, nb, mode, 1'b1);
            end
        end
        idle_cycle();
        for (int k = 0; k < 64; k++) begin
            r = 0;
            for (int j = 0; j < 64; j++)
                if (e[j] > e[k] || (e[j] == e[k] && j < k)) r++;
            if (r < 16) exp_idx[r] = k;
        end
    endtask

    task automatic expect_result(input string tag);
        int n = 0;
        while (!sort_sop && n < 1100) begin
            @(negedge clk);
            n++;
        end
        if (!sort_sop) begin
            check({tag, "_sop_timeout"}, 0, 1);
        end else begin
            check({tag, "_sop_lat"}, cyc - t_eop, 1044);
            check({tag, "_busy"}, busy, 0);
            for (int i = 0; i < 16; i++)
                check($sformatf("%s_idx%0d", tag, i), sort_idx[i], exp_idx[i]);
        end
        idle_cycle();
    endtask

    initial begin
        int s0, o0;
        rst   = 1'b1;
        valid = 1'b0;
        sop   = 1'b0;
        eop   = 1'b0;
        data  = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 16; i++)
            check($sformatf("rst_idx%0d", i), sort_idx[i], i);
        check("rst_sop", sort_sop, 0);
        check("rst_busy", busy, 0);
        check("rst_ovr", overrun, 0);

        send_symbol(0);
        expect_result("distinct");
        send_symbol(1);
        expect_result("tie");
        send_symbol(2);
        expect_result("tie40");
        send_symbol(3);
        expect_result("sat");
        for (int n = 0; n < 3; n++) begin
            send_symbol(4);
            expect_result($sformatf("rand%0d", n));
        end

        send_symbol(4);
        while (cyc < t_eop + 500) @(negedge clk);
        o0 = ovr_cnt;
        for (int k = 0; k < 3; k++) drive_beat(0, k, 3, 4, 1'b0);
        idle_cycle();
        expect_result("ovr");
        check("ovr_pulses", ovr_cnt - o0, 3);
        s0 = sop_cnt;
        repeat (1200) @(negedge clk);
        check("ovr_no_sop", sop_cnt - s0, 0);
        check("ovr_busy", busy, 0);

        send_symbol(4);
        while (cyc < t_eop + 600) @(negedge clk);
        rst = 1'b1;
        s0  = sop_cnt;
        @(negedge clk);
        rst = 1'b0;
        repeat (600) @(negedge clk);
        check("midrst_no_sop", sop_cnt - s0, 0);
        check("midrst_busy", busy, 0);
        for (int i = 0; i < 16; i++)
            check($sformatf("midrst_idx%0d", i), sort_idx[i], i);
        send_symbol(4);
        expect_result("after_rst");

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
